// File: rtl/branch_resolve_unit_if.sv
// Branch resolve unit bus: the ID-stage branch information, the EX outcome
// and the redirect/flush/update signals back to the pipeline.
// Optional feature macro: BRU_STATS_EN adds BranchCount/MispredictCount.
interface branch_resolve_unit_if #(
   parameter int W = 32
`ifdef BRU_STATS_EN
   ,parameter int CNT_W = 16
`endif
) ();
   logic          BranchInstructExists_ID;
   logic          Prediction_ID;
   logic [W-1:0]  PCPlus4_ID;
   logic [W-1:0]  BranchTarget_ID;
   logic          Stall_ID;
   logic          BranchDecision_EX;

   logic          BranchInstructExists_EX;
   logic          Mispredict_EX;
   logic          RedirectValid;
   logic [W-1:0]  RedirectPC;
   logic          Flush;
   logic          Busy;
`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] BranchCount;
   logic [CNT_W-1:0] MispredictCount;
`endif

   // Pipeline side: drives the ID branch and the EX outcome, consumes the results
   modport master (
      output BranchInstructExists_ID, Prediction_ID, PCPlus4_ID, BranchTarget_ID,
             Stall_ID, BranchDecision_EX,
      input  BranchInstructExists_EX, Mispredict_EX, RedirectValid, RedirectPC,
             Flush, Busy
`ifdef BRU_STATS_EN
      ,input BranchCount, MispredictCount
`endif
   );

   // Resolve unit side
   modport slave (
      input  BranchInstructExists_ID, Prediction_ID, PCPlus4_ID, BranchTarget_ID,
             Stall_ID, BranchDecision_EX,
      output BranchInstructExists_EX, Mispredict_EX, RedirectValid, RedirectPC,
             Flush, Busy
`ifdef BRU_STATS_EN
      ,output BranchCount, MispredictCount
`endif
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries the ID-stage prediction of a branch into EX,
// compares it against the real outcome, strobes the predictor update and on
// a mispredict redirects fetch and flushes the front end for FLUSH_CYCLES.
// Optional feature macro: BRU_STATS_EN (saturating branch/mispredict counters).
module branch_resolve_unit #(
   parameter int W            = 32,
   parameter int FLUSH_CYCLES = 1
`ifdef BRU_STATS_EN
   ,parameter int CNT_W       = 16
`endif
) (
   input logic                  Clock,
   input logic                  Reset_n,
   branch_resolve_unit_if.slave bru
);

   // Recovery counter start value; the mispredict cycle itself is the first flush cycle
   localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RECOVER = 1'b1
   } state_t;

   state_t          r_state;
   logic [2:0]      r_cnt;
   logic            r_busy;

   logic            r_valid;
   logic            r_pred;
   logic [W-1:0]    r_pc4;
   logic [W-1:0]    r_tgt;

   logic            w_mispredict;
   logic            w_flush;
   logic            w_loadSlot;

   // A valid EX branch whose stored prediction disagrees with the real outcome
   assign w_mispredict = r_valid & (r_pred != bru.BranchDecision_EX);
   assign w_flush      = w_mispredict | r_busy;
   // A flushed or stalled ID branch must never reach EX
   assign w_loadSlot   = bru.BranchInstructExists_ID & ~bru.Stall_ID & ~w_flush & ~r_busy;

   // ID->EX slot: valid follows every edge, payload only captured for a real branch
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_valid <= 1'b0;
         r_pred  <= 1'b0;
         r_pc4   <= '0;
         r_tgt   <= '0;
      end else begin
         r_valid <= w_loadSlot;
         if (w_loadSlot) begin
            r_pred <= bru.Prediction_ID;
            r_pc4  <= bru.PCPlus4_ID;
            r_tgt  <= bru.BranchTarget_ID;
         end
      end
   end

   // Recovery FSM: stretches Flush past the mispredict cycle when FLUSH_CYCLES > 1
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
         r_cnt   <= 3'd0;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mispredict && (FLUSH_CYCLES > 1)) begin
                  r_state <= RECOVER;
                  r_cnt   <= CNT_INIT;
                  r_busy  <= 1'b1;
               end
            end
            RECOVER: begin
               if (r_cnt == 3'd1) begin
                  r_state <= IDLE;
                  r_cnt   <= 3'd0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt - 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 3'd0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bru.BranchInstructExists_EX = r_valid;
   assign bru.Mispredict_EX           = w_mispredict;
   assign bru.RedirectValid           = w_mispredict;
   assign bru.RedirectPC              = w_mispredict ? (bru.BranchDecision_EX ? r_tgt : r_pc4) : '0;
   assign bru.Flush                   = w_flush;
   assign bru.Busy                    = r_busy;

`ifdef BRU_STATS_EN
   logic [CNT_W-1:0] r_branchCount;
   logic [CNT_W-1:0] r_mispredictCount;

   // Statistics: count resolved branches and mispredicts, sticking at all-ones
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_branchCount     <= '0;
         r_mispredictCount <= '0;
      end else begin
         if (r_valid && (r_branchCount != '1)) begin
            r_branchCount <= r_branchCount + 1'b1;
         end
         if (w_mispredict && (r_mispredictCount != '1)) begin
            r_mispredictCount <= r_mispredictCount + 1'b1;
         end
      end
   end

   assign bru.BranchCount     = r_branchCount;
   assign bru.MispredictCount = r_mispredictCount;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: two instances (FLUSH_CYCLES 1 and 3)
// driven with identical inputs and compared against a cycle-level model.
module tb_branch_resolve_unit;

   localparam int W    = 32;
   localparam int FC_A = 1;
   localparam int FC_B = 3;
`ifdef BRU_STATS_EN
   localparam int CNT_W = 4;
`endif

   logic Clock;
   logic Reset_n;

   int cmpCount;
   int errCount;

   // Reference model per instance: EX slot contents and remaining flush cycles
   bit            mValid[2];
   bit            mPred[2];
   logic [W-1:0]  mPc4[2];
   logic [W-1:0]  mTgt[2];
   int            mFlushLeft[2];
   int            mBrCnt[2];
   int            mMisCnt[2];

`ifdef BRU_STATS_EN
   branch_resolve_unit_if #(.W(W), .CNT_W(CNT_W)) busA ();
   branch_resolve_unit_if #(.W(W), .CNT_W(CNT_W)) busB ();
   branch_resolve_unit #(.W(W), .FLUSH_CYCLES(FC_A), .CNT_W(CNT_W)) dutA (
      .Clock(Clock), .Reset_n(Reset_n), .bru(busA));
   branch_resolve_unit #(.W(W), .FLUSH_CYCLES(FC_B), .CNT_W(CNT_W)) dutB (
      .Clock(Clock), .Reset_n(Reset_n), .bru(busB));
`else
   branch_resolve_unit_if #(.W(W)) busA ();
   branch_resolve_unit_if #(.W(W)) busB ();
   branch_resolve_unit #(.W(W), .FLUSH_CYCLES(FC_A)) dutA (
      .Clock(Clock), .Reset_n(Reset_n), .bru(busA));
   branch_resolve_unit #(.W(W), .FLUSH_CYCLES(FC_B)) dutB (
      .Clock(Clock), .Reset_n(Reset_n), .bru(busB));
`endif

   // Free-running clock, 10 time units per cycle
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      cmpCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   function automatic int flushCyclesOf(input int i);
      return (i == 0) ? FC_A : FC_B;
   endfunction

`ifdef BRU_STATS_EN
   function automatic logic [63:0] satCount(input int n);
      int maxVal;
      maxVal = (1 << CNT_W) - 1;
      return (n > maxVal) ? 64'(maxVal) : 64'(n);
   endfunction
`endif

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mValid[i]     = 1'b0;
         mPred[i]      = 1'b0;
         mPc4[i]       = '0;
         mTgt[i]       = '0;
         mFlushLeft[i] = 0;
         mBrCnt[i]     = 0;
         mMisCnt[i]    = 0;
      end
   endtask

   task automatic driveInputs(input bit ex, input bit pred, input logic [W-1:0] pc4,
                              input logic [W-1:0] tgt, input bit stall, input bit dec);
      busA.BranchInstructExists_ID = ex;
      busA.Prediction_ID           = pred;
      busA.PCPlus4_ID              = pc4;
      busA.BranchTarget_ID         = tgt;
      busA.Stall_ID                = stall;
      busA.BranchDecision_EX       = dec;
      busB.BranchInstructExists_ID = ex;
      busB.Prediction_ID           = pred;
      busB.PCPlus4_ID              = pc4;
      busB.BranchTarget_ID         = tgt;
      busB.Stall_ID                = stall;
      busB.BranchDecision_EX       = dec;
   endtask

   task automatic checkInstance(input string name, input int i, input bit dec,
                                input logic actExists, input logic actMis, input logic actRv,
                                input logic [W-1:0] actRpc, input logic actFlush, input logic actBusy);
      bit           mis;
      bit           busy;
      logic [W-1:0] rpc;
      mis  = mValid[i] && (mPred[i] != dec);
      busy = (mFlushLeft[i] > 0);
      rpc  = mis ? (dec ? mTgt[i] : mPc4[i]) : '0;
      checkOutput({name, ".exists"},     64'(actExists), 64'(mValid[i]));
      checkOutput({name, ".mispredict"}, 64'(actMis),    64'(mis));
      checkOutput({name, ".redirValid"}, 64'(actRv),     64'(mis));
      checkOutput({name, ".redirPC"},    64'(actRpc),    64'(rpc));
      checkOutput({name, ".flush"},      64'(actFlush),  64'(mis || busy));
      checkOutput({name, ".busy"},       64'(actBusy),   64'(busy));
   endtask

   task automatic modelAdvance(input int i, input bit ex, input bit pred, input logic [W-1:0] pc4,
                               input logic [W-1:0] tgt, input bit stall, input bit dec);
      bit mis;
      bit flush;
      bit nextValid;
      mis       = mValid[i] && (mPred[i] != dec);
      flush     = mis || (mFlushLeft[i] > 0);
      nextValid = ex && !stall && !flush;
      if (mValid[i]) mBrCnt[i]++;
      if (mis) mMisCnt[i]++;
      if (mis) mFlushLeft[i] = flushCyclesOf(i) - 1;
      else if (mFlushLeft[i] > 0) mFlushLeft[i]--;
      if (nextValid) begin
         mPred[i] = pred;
         mPc4[i]  = pc4;
         mTgt[i]  = tgt;
      end
      mValid[i] = nextValid;
   endtask

   // One clock cycle: drive ID/EX inputs, check both instances, step the model
   task automatic applyStimulus(input bit ex, input bit pred, input logic [W-1:0] pc4,
                                input logic [W-1:0] tgt, input bit stall, input bit dec);
      @(posedge Clock);
      #1;
      driveInputs(ex, pred, pc4, tgt, stall, dec);
      #1;
      checkInstance("A", 0, dec, busA.BranchInstructExists_EX, busA.Mispredict_EX, busA.RedirectValid,
                    busA.RedirectPC, busA.Flush, busA.Busy);
      checkInstance("B", 1, dec, busB.BranchInstructExists_EX, busB.Mispredict_EX, busB.RedirectValid,
                    busB.RedirectPC, busB.Flush, busB.Busy);
`ifdef BRU_STATS_EN
      checkOutput("A.branchCount", 64'(busA.BranchCount),     satCount(mBrCnt[0]));
      checkOutput("A.mispCount",   64'(busA.MispredictCount), satCount(mMisCnt[0]));
      checkOutput("B.branchCount", 64'(busB.BranchCount),     satCount(mBrCnt[1]));
      checkOutput("B.mispCount",   64'(busB.MispredictCount), satCount(mMisCnt[1]));
`endif
      for (int i = 0; i < 2; i++) modelAdvance(i, ex, pred, pc4, tgt, stall, dec);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".A.exists"}, 64'(busA.BranchInstructExists_EX), 64'd0);
      checkOutput({tag, ".A.misp"},   64'(busA.Mispredict_EX),           64'd0);
      checkOutput({tag, ".A.rv"},     64'(busA.RedirectValid),           64'd0);
      checkOutput({tag, ".A.rpc"},    64'(busA.RedirectPC),              64'd0);
      checkOutput({tag, ".A.flush"},  64'(busA.Flush),                   64'd0);
      checkOutput({tag, ".A.busy"},   64'(busA.Busy),                    64'd0);
      checkOutput({tag, ".B.exists"}, 64'(busB.BranchInstructExists_EX), 64'd0);
      checkOutput({tag, ".B.misp"},   64'(busB.Mispredict_EX),           64'd0);
      checkOutput({tag, ".B.rpc"},    64'(busB.RedirectPC),              64'd0);
      checkOutput({tag, ".B.flush"},  64'(busB.Flush),                   64'd0);
      checkOutput({tag, ".B.busy"},   64'(busB.Busy),                    64'd0);
`ifdef BRU_STATS_EN
      checkOutput({tag, ".A.brCnt"},  64'(busA.BranchCount),             64'd0);
      checkOutput({tag, ".B.misCnt"}, 64'(busB.MispredictCount),         64'd0);
`endif
   endtask

   // Asynchronous reset in the middle of a cycle, released away from the clock edge
   task automatic resetPulse();
      @(posedge Clock);
      #1;
      checkOutput("B.busyBeforeReset", 64'(busB.Busy), 64'(mFlushLeft[1] > 0));
      Reset_n = 1'b0;
      driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      #1;
      checkAllZero("rst");
      modelReset();
      @(posedge Clock);
      #3;
      Reset_n = 1'b1;
   endtask

   initial begin
      cmpCount = 0;
      errCount = 0;
      Reset_n  = 1'b0;
      driveInputs(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      modelReset();
      #2;
      checkAllZero("por");
      @(posedge Clock);
      #3;
      Reset_n = 1'b1;

      // Predicted not-taken, actually not-taken
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h200, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("tp1.exists", 64'(busA.BranchInstructExists_EX), 64'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // Predicted not-taken, actually taken
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h200, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("tp2.redirPC", 64'(busA.RedirectPC), 64'h200);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // Predicted taken, actually not-taken, with an ID branch during the flush
      applyStimulus(1'b1, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h300, 32'h400, 1'b0, 1'b0);
      checkOutput("tp3.redirPC", 64'(busB.RedirectPC), 64'h40);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("tp3.flushedA", 64'(busA.BranchInstructExists_EX), 64'd0);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // Stalled ID branch never reaches EX; stall coinciding with a mispredict
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h20, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h20, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 32'h30, 32'h34, 1'b1, 1'b1);
      checkOutput("tp4.redirPC", 64'(busA.RedirectPC), 64'h20);
      for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // Reset during the second flush cycle of the 3-cycle instance, then a normal branch
      applyStimulus(1'b1, 1'b0, 32'h104, 32'h200, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      resetPulse();
      applyStimulus(1'b1, 1'b1, 32'h500, 32'h600, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      checkOutput("tp5.redirPC", 64'(busB.RedirectPC), 64'h500);

      // Randomized traffic with occasional resets
      for (int k = 0; k < 600; k++) begin
         if (k % 200 == 199) resetPulse();
         applyStimulus(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), W'($urandom),
                       W'($urandom), 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- EX-stage consumer of the branch predictor's ID-stage Prediction.
- Latches each ID branch's prediction, fall-through PC and target PC, and carries them one stage to EX.
- In EX, compares the prediction with the actual BranchDecision_EX and issues the predictor update strobe (BranchInstructExists_EX).
- On a mispredict, drives the PC redirect and a pipeline flush.

Parameters:
- W, 32, PC width in bits.
- FLUSH_CYCLES, 1, cycles Flush is held per mispredict. Legal range is 1..7.
- CNT_W, 16, statistics counter width. Used only with BRU_STATS_EN.

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- BranchInstructExists_ID  in  1  a branch is in ID this cycle.
- Prediction_ID  in  1  predictor output for the ID branch; 1 = taken.
- PCPlus4_ID  in  W  fall-through address of the ID branch.
- BranchTarget_ID  in  W  taken address of the ID branch.
- Stall_ID  in  1  ID is held this cycle, so EX receives a bubble.
- BranchDecision_EX  in  1  actual outcome from the EX comparator; 1 = taken.
- BranchInstructExists_EX  out  1  a valid branch is in EX. Goes to the predictor update port.
- Mispredict_EX  out  1  the EX branch was mispredicted.
- RedirectValid  out  1  the PC must load RedirectPC at the next edge.
- RedirectPC  out  W  corrected fetch address.
- Flush  out  1  squash IF/ID and ID/EX contents.
- Busy  out  1  recovery in progress.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - EX slot valid=0; stored prediction and PCs = 0.
  - FSM to IDLE; flush counter = 0.
  - All outputs 0, and counters 0 when stats are enabled.
  - Reset during RECOVER aborts recovery immediately.
- ID->EX slot, loaded on every rising edge:
  - valid <= BranchInstructExists_ID & ~Stall_ID & ~Flush & ~Busy.
  - pred, pc4 and tgt <= Prediction_ID, PCPlus4_ID, BranchTarget_ID. Loaded only when the new valid is 1; otherwise held.
  - Flush or Busy overrides a simultaneous ID branch, so a flushed branch never reaches EX.
- EX outputs (combinational from the slot and BranchDecision_EX):
  - BranchInstructExists_EX = valid. It is high exactly one cycle per resolved branch, so the predictor updates once.
  - Mispredict_EX = valid & (pred != BranchDecision_EX).
  - RedirectValid = Mispredict_EX.
  - RedirectPC = BranchDecision_EX ? tgt : pc4. It is 0 when RedirectValid=0.
  - A correct prediction causes no redirect and no flush; there is zero-cycle overhead.
- FSM states:
  - IDLE: Flush = Mispredict_EX and Busy = 0.
    - Mispredict with FLUSH_CYCLES=1: stay in IDLE.
    - Mispredict with FLUSH_CYCLES>1: go to RECOVER and load cnt = FLUSH_CYCLES-1.
  - RECOVER: Flush = 1 and Busy = 1.
    - EX slot is forced invalid, so no mispredict can occur here.
    - cnt decrements each cycle. At cnt==1, return to IDLE on the next edge.
  - The total Flush width per mispredict is exactly FLUSH_CYCLES cycles, starting in the mispredict cycle.
- Back-to-back branches:
  - Consecutive valid EX branches are allowed when no mispredict occurs.
  - After a mispredict, the earliest next valid EX branch is FLUSH_CYCLES+1 cycles later.
- Stall_ID and a mispredict in the same cycle: the mispredict is honoured and the bubble is inserted.
- BranchDecision_EX is ignored when valid=0.

Optional Feature:
- BRU_STATS_EN defined:
  - Adds outputs BranchCount [CNT_W] and MispredictCount [CNT_W].
  - BranchCount increments on each BranchInstructExists_EX; MispredictCount increments on each Mispredict_EX.
  - Both saturate at all-ones (no wrap) and reset to 0.
- BRU_STATS_EN undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Predicted not-taken, actual not-taken. ID branch with Prediction_ID=0, PCPlus4_ID=0x104, BranchTarget_ID=0x200; next cycle BranchDecision_EX=0 -> BranchInstructExists_EX=1 for 1 cycle; Mispredict_EX=0, Flush=0, RedirectValid=0.
- Predicted not-taken, actual taken. Same branch with BranchDecision_EX=1 -> Mispredict_EX=1, RedirectValid=1, RedirectPC=0x200, Flush=1 for 1 cycle. With FLUSH_CYCLES=3: Flush high 3 cycles, Busy high 2 cycles.
- Predicted taken, actual not-taken. Prediction_ID=1, PCPlus4_ID=0x40, BranchTarget_ID=0x80, BranchDecision_EX=0 -> RedirectPC=0x40. A branch presented in ID during the Flush cycle never raises BranchInstructExists_EX.
- Stall and reset. ID branch with Stall_ID=1 -> EX slot stays invalid. With FLUSH_CYCLES=3, Reset_n=0 asserted in the 2nd Flush cycle -> Flush, Busy and all outputs are 0 immediately, and after release the next branch resolves normally.
- Stats (BRU_STATS_EN, CNT_W=4). 20 branches with 5 mispredicts -> BranchCount=15 (saturated), MispredictCount=5.
